mul_issue: RTL and testbench

- Operand-issue and result-capture stage in front of the inferred multiplier.
- Accepts multiply requests on a valid/ready port and buffers them in a small FIFO.
- Issues one request at a time to the multiplier, using the multiplier's reset input as the start strobe, and waits for its done.
- Returns each product on a valid/ready response port, in request order.

---
 rtl/mul_pkg.sv | 25 ++
 rtl/mul_issue_if.sv | 33 +++
 rtl/mul_req_fifo.sv | 50 +++++
 rtl/mul_issue.sv | 158 +++++++++++++++
 tb/tb_mul_issue.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared types for the multiplier issue stage.
// Request entry layout, FSM states and product-word select constants.
package mul_pkg;

  localparam int MUL_W = 32;

  localparam logic MUL_TYPE_LO = 1'b0;
  localparam logic MUL_TYPE_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_t;

  typedef struct packed {
    logic [MUL_W-1:0] a;
    logic [MUL_W-1:0] b;
    logic             a_signed;
    logic             b_signed;
    logic             mul_type;
  } mul_req_t;

endpackage

// File: rtl/mul_issue_if.sv
// Request and response handshake bundle of the multiplier issue stage.
// master = requester/consumer side, slave = mul_issue.
interface mul_issue_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_a_signed;
  logic             req_b_signed;
  logic             req_mul_type;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_error;

  modport master (
    output req_valid, req_a, req_b,
    output req_a_signed, req_b_signed,
    output req_mul_type, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_result, rsp_error
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_a_signed, req_b_signed,
    input  req_mul_type, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_result, rsp_error
  );
endinterface

// File: rtl/mul_req_fifo.sv
// Synchronous request FIFO, power-of-two depth.
// Pointers carry one extra wrap bit to tell full from empty.
module mul_req_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wp_q, wp_d;
  logic [AW:0]       rp_q, rp_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[AW] != rp_q[AW]) &&
                 (wp_q[AW-1:0] == rp_q[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rp_q[AW-1:0]];

  always_comb begin
    wp_d = wp_q + {{AW{1'b0}}, do_push};
    rp_d = rp_q + {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mul_issue.sv
// Operand issue / result capture in front of the inferred multiplier.
// Define MUL_ISSUE_TIMEOUT_EN to build the RUN-state watchdog.
module mul_issue
  import mul_pkg::*;
#(
  parameter int WIDTH          = MUL_W,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  mul_issue_if.slave       bus,
  output logic [WIDTH-1:0] mul_inpA,
  output logic [WIDTH-1:0] mul_inpB,
  output logic             mul_a_signed,
  output logic             mul_b_signed,
  output logic             mul_type,
  output logic             mul_reset,
  input  logic             mul_done,
  input  logic [WIDTH-1:0] mul_out
);
  state_t           state_q, state_d;
  mul_req_t         op_q, op_d;
  mul_req_t         wr_ent, head;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;
  logic             tmo_hit;

  assign bus.req_ready = !reset && !fifo_full;
  assign fifo_push     = bus.req_valid && bus.req_ready;

  assign wr_ent = '{a:        bus.req_a,
                    b:        bus.req_b,
                    a_signed: bus.req_a_signed,
                    b_signed: bus.req_b_signed,
                    mul_type: bus.req_mul_type};

  mul_req_fifo #(
    .DATA_W ($bits(mul_req_t)),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (wr_ent),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head;
          state_d  = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (mul_done) begin
          rsp_result_d = mul_out;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else if (tmo_hit) begin
          rsp_result_d = '0;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        // Chain straight into LOAD so back-to-back ops skip IDLE.
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            op_d     = head;
            state_d  = LOAD;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
    end
  end

`ifdef MUL_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_error_q, rsp_error_d;

  assign tmo_hit = (state_q == RUN) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_d       = tmo_q;
    rsp_error_d = rsp_error_q;
    if (state_q == LOAD)     tmo_d = '0;
    else if (state_q == RUN) tmo_d = tmo_q + 1'b1;
    if (state_q == RUN && !mul_done && tmo_hit)
      rsp_error_d = 1'b1;
    else if (state_q == RESP && bus.rsp_ready)
      rsp_error_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q       <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      tmo_q       <= tmo_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign bus.rsp_error = rsp_error_q;
`else
  assign tmo_hit       = 1'b0;
  assign bus.rsp_error = 1'b0;
`endif

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;

  // Outside RUN the multiplier is held, so a stale done is never seen.
  assign mul_reset    = reset || (state_q != RUN);
  assign mul_inpA     = op_q.a;
  assign mul_inpB     = op_q.b;
  assign mul_a_signed = op_q.a_signed;
  assign mul_b_signed = op_q.b_signed;
  assign mul_type     = op_q.mul_type;

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue with a 5-cycle multiplier model.
// Timeout sequence is built when MUL_ISSUE_TIMEOUT_EN is defined.
module tb_mul_issue;
  import mul_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        as;
    logic        bs;
    logic        ty;
    logic [32:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mul_issue_if #(.WIDTH(W)) bus ();

  logic [W-1:0] mul_inpA, mul_inpB, mul_out;
  logic mul_a_signed, mul_b_signed, mul_type;
  logic mul_reset, mul_done;

  mul_issue #(
    .WIDTH          (W),
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .mul_inpA     (mul_inpA),
    .mul_inpB     (mul_inpB),
    .mul_a_signed (mul_a_signed),
    .mul_b_signed (mul_b_signed),
    .mul_type     (mul_type),
    .mul_reset    (mul_reset),
    .mul_done     (mul_done),
    .mul_out      (mul_out)
  );

  // Multiplier model: done in the 5th cycle after reset drops.
  int   mcnt;
  bit   no_done;
  logic [63:0] ea, eb, prod;

  always @(posedge clk) begin
    if (mul_reset) mcnt <= 0;
    else if (mcnt < 1000) mcnt <= mcnt + 1;
  end

  assign ea = mul_a_signed ? {{32{mul_inpA[31]}}, mul_inpA}
                           : {32'b0, mul_inpA};
  assign eb = mul_b_signed ? {{32{mul_inpB[31]}}, mul_inpB}
                           : {32'b0, mul_inpB};
  assign prod     = ea * eb;
  assign mul_out  = mul_type ? prod[63:32] : prod[31:0];
  assign mul_done = !mul_reset && !no_done && (mcnt == 4);

  logic [32:0] got_q[$];

  always @(negedge clk) begin
    if (reset) got_q.delete();
    else if (bus.rsp_valid && bus.rsp_ready)
      got_q.push_back({bus.rsp_error, bus.rsp_result});
  end

  int n_cmp;
  int n_bad;
  vec_t tbl[10];

  function automatic void chk(string nm,
                              logic [63:0] act,
                              logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.req_valid    = 1'b1;
    bus.req_a        = v.a;
    bus.req_b        = v.b;
    bus.req_a_signed = v.as;
    bus.req_b_signed = v.bs;
    bus.req_mul_type = v.ty;
  endtask

  task automatic push(input vec_t v, output int stalls);
    stalls = 0;
    drive(v);
    while (!bus.req_ready && stalls < 200) begin
      step();
      stalls++;
    end
    if (stalls >= 200) chk("push_stall", stalls, 0);
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic drain(input int n, input string nm);
    int k;
    k = 0;
    while (got_q.size() < n && k < 400) begin
      step();
      k++;
    end
    chk(nm, got_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st[10];
    int n, nlo, nv, first_lo, first_v, unstable, acc;
    logic [31:0] held, ld_a;
    logic tr_rst[12];
    logic tr_v[12];
    vec_t one;

    tbl[0] = '{32'd3, 32'd7, 1'b1, 1'b1, MUL_TYPE_LO, 33'd21};
    tbl[1] = '{32'hFFFFFFFE, 32'd5, 1'b1, 1'b1, MUL_TYPE_LO,
               33'h0_FFFFFFF6};
    tbl[2] = '{32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, MUL_TYPE_LO,
               33'h0_FFFFFFFF};
    tbl[3] = '{32'd100, 32'd100, 1'b1, 1'b1, MUL_TYPE_LO,
               33'd10000};
    tbl[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, MUL_TYPE_HI,
               33'h0_FFFFFFFE};
    tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, MUL_TYPE_HI,
               33'h0};
    tbl[6] = '{32'h80000000, 32'd2, 1'b1, 1'b1, MUL_TYPE_HI,
               33'h0_FFFFFFFF};
    tbl[7] = '{32'h80000000, 32'd2, 1'b0, 1'b0, MUL_TYPE_HI,
               33'h1};
    tbl[8] = '{32'hFFFFFFFF, 32'd2, 1'b1, 1'b0, MUL_TYPE_HI,
               33'h0_FFFFFFFF};
    tbl[9] = '{32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, MUL_TYPE_HI,
               33'h1};
    one = '{32'd16384, 32'd4, 1'b1, 1'b1, MUL_TYPE_LO, 33'd65536};

    n_cmp = 0;
    n_bad = 0;
    no_done = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a_signed = 1'b0;
    bus.req_b_signed = 1'b0;
    bus.req_mul_type = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset values
    step();
    step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_error", bus.rsp_error, 0);
    chk("rst_mul_reset", mul_reset, 1);
    chk("rst_mul_ops", {mul_inpA, mul_inpB, mul_a_signed,
                        mul_b_signed, mul_type}, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.req_ready, 1);

    // Single request, cycle-accurate trace
    bus.rsp_ready = 1'b1;
    push(one, st[0]);
    ld_a = '0;
    for (int i = 0; i < 12; i++) begin
      tr_rst[i] = mul_reset;
      tr_v[i] = bus.rsp_valid;
      if (i == 1) ld_a = mul_inpA;
      step();
    end
    nlo = 0; nv = 0; first_lo = -1; first_v = -1;
    for (int i = 0; i < 12; i++) begin
      if (!tr_rst[i]) begin
        nlo++;
        if (first_lo < 0) first_lo = i;
      end
      if (tr_v[i]) begin
        nv++;
        if (first_v < 0) first_v = i;
      end
    end
    chk("one_load_rst", tr_rst[1], 1);
    chk("one_load_opA", ld_a, 32'd16384);
    chk("one_run_cycles", nlo, 5);
    chk("one_run_start", first_lo, 2);
    chk("one_rsp_cycles", nv, 1);
    chk("one_rsp_at", first_v, 7);
    chk("one_rsp_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("one_result", got_q[0], one.exp);

    // Back-to-back table with rsp_ready held high
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) push(tbl[i], st[i]);
    acc = 0;
    for (int i = 0; i < 5; i++) acc += st[i];
    chk("b2b_no_stall_until_full", acc, 0);
    chk("b2b_stall_when_full", st[5] > 0, 1);
    drain(10, "b2b_count");
    for (int i = 0; i < 10; i++)
      if (i < got_q.size())
        chk($sformatf("b2b_rsp%0d", i), got_q[i], tbl[i].exp);

    // Backpressure, then full FIFO with simultaneous pop
    do_reset();
    bus.rsp_ready = 1'b0;
    push(tbl[0], st[0]);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      step();
      n++;
    end
    chk("bp_rsp_seen", bus.rsp_valid, 1);
    held = bus.rsp_result;
    chk("bp_first_result", held, tbl[0].exp[31:0]);
    unstable = 0;
    acc = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      drive(tbl[(i < 4) ? i + 1 : 5]);
      if (bus.req_ready) begin
        if (i < 4) acc++;
        else n++;
      end
      if (!bus.rsp_valid || bus.rsp_result != held) unstable++;
      step();
    end
    chk("bp_stable", unstable, 0);
    chk("bp_fill", acc, 4);
    chk("bp_full_ready", n, 0);
    bus.rsp_ready = 1'b1;
    chk("fp_hs_ready", bus.req_ready, 0);
    step();
    chk("fp_next_ready", bus.req_ready, 1);
    chk("fp_next_valid", bus.rsp_valid, 0);
    step();
    bus.req_valid = 1'b0;
    drain(6, "fp_count");
    for (int i = 0; i < 6; i++)
      if (i < got_q.size())
        chk($sformatf("fp_rsp%0d", i), got_q[i], tbl[i].exp);
    for (int i = 0; i < 20; i++) step();
    chk("fp_no_dup", got_q.size(), 6);

    // Reset during RUN with two entries queued
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) push(tbl[i], st[i]);
    n = 0;
    while (mul_reset && n < 20) begin
      step();
      n++;
    end
    chk("mr_in_run", mul_reset, 0);
    reset = 1'b1;
    #1;
    chk("mr_rst_mul_reset", mul_reset, 1);
    step();
    reset = 1'b0;
    #1;
    chk("mr_rsp_valid", bus.rsp_valid, 0);
    chk("mr_mul_reset", mul_reset, 1);
    chk("mr_req_ready", bus.req_ready, 1);
    nlo = 0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      if (!mul_reset) nlo++;
      if (bus.rsp_valid) nv++;
      step();
    end
    chk("mr_no_run", nlo, 0);
    chk("mr_no_valid", nv, 0);
    chk("mr_no_rsp", got_q.size(), 0);

`ifdef MUL_ISSUE_TIMEOUT_EN
    do_reset();
    bus.rsp_ready = 1'b1;
    no_done = 1'b1;
    push('{32'd5, 32'd6, 1'b0, 1'b0, MUL_TYPE_LO, 33'h1_00000000},
         st[0]);
    push('{32'd7, 32'd8, 1'b0, 1'b0, MUL_TYPE_LO, 33'd56}, st[1]);
    n = 0;
    while (mul_reset && n < 20) begin
      step();
      n++;
    end
    chk("to_in_run", mul_reset, 0);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", n, 9);
    chk("to_error", bus.rsp_error, 1);
    chk("to_result", bus.rsp_result, 0);
    no_done = 1'b0;
    drain(2, "to_count");
    if (got_q.size() > 0) chk("to_rsp0", got_q[0], 33'h1_00000000);
    if (got_q.size() > 1) chk("to_rsp1", got_q[1], 33'd56);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
